// File: rtl/cordic_deser.sv
// cordic_deser: bit-serial to parallel output stage for the bit-serial CORDIC core.
// Collects three LSB-first result streams during each WIDTH-cycle valid window and
// queues the reassembled X/Y/Z words in a 2-entry ready/valid FIFO.
// Optional build macro: CORDIC_DESER_DROP_FIRST_EN discards the first complete
// word after reset, which holds the core's post-clear garbage.
module cordic_deser #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    input  logic             xs,
    input  logic             ys,
    input  logic             zs,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
    } word_t;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] xsr, ysr, zsr;
    word_t            head, tail, word_in;
    logic [1:0]       count;
    logic             complete, push, pop;

    // Completed word includes the bit being sampled this cycle.
    assign word_in  = {{xs, xsr[WIDTH-1:1]}, {ys, ysr[WIDTH-1:1]}, {zs, zsr[WIDTH-1:1]}};
    assign complete = in_valid && (cnt == CW'(WIDTH-1));
    assign pop      = out_valid && out_ready;

`ifdef CORDIC_DESER_DROP_FIRST_EN
    logic first_word;

    // First-word flag: cleared only by a full completion, not by an aborted frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)       first_word <= 1'b1;
        else if (complete) first_word <= 1'b0;
    end

    assign push = complete && !first_word;
`else
    assign push = complete;
`endif

    // Serial capture: shift in at the MSB, count bits, flag windows that end early.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt       <= '0;
            xsr       <= '0;
            ysr       <= '0;
            zsr       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= !in_valid && (cnt != '0);
            if (in_valid) begin
                xsr <= {xs, xsr[WIDTH-1:1]};
                ysr <= {ys, ysr[WIDTH-1:1]};
                zsr <= {zs, zsr[WIDTH-1:1]};
                cnt <= complete ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // 2-entry FIFO: head is a register that drives the outputs directly, tail
    // backs it up. A pop shifts tail into head so the next word shows with no bubble.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= word_in;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= word_in;
                    end else if (push) begin
                        tail  <= word_in;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        if (push) tail  <= word_in;
                        else      count <= 2'd1;
                    end else if (push) begin
                        overflow <= 1'b1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_x     = head.x;
    assign out_y     = head.y;
    assign out_z     = head.z;

endmodule

// File: tb/tb_cordic_deser.sv
// Directed, table-driven bench for cordic_deser. Inputs change 1 time unit after
// the rising edge, outputs are sampled at that same point, away from the edge.
module tb_cordic_deser;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             in_valid, xs, ys, zs, out_ready;
    logic [WIDTH-1:0] out_x, out_y, out_z;
    logic             out_valid, overflow, frame_err;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] x, y, z;
        logic [15:0] ex, ey, ez;
    } vec_t;

    vec_t vecs[6];

    cordic_deser #(.WIDTH(WIDTH)) dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid),
        .xs(xs), .ys(ys), .zs(zs),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive n bits of a word LSB first; optionally raise out_ready on the last bit.
    task automatic send_bits(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                             input int n, input bit rdy_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            xs = x[i];
            ys = y[i];
            zs = z[i];
            if (rdy_last && i == n - 1) out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // With the drop-first build, burn the first word and confirm nothing appears.
    task automatic prime();
`ifdef CORDIC_DESER_DROP_FIRST_EN
        send_bits(16'h1234, 16'hFEDC, 16'h0C91, 16, 1'b0);
        in_valid = 1'b0;
        chk("first word dropped", {47'd0, out_valid}, 48'd0);
        chk("first word no ferr", {47'd0, frame_err}, 48'd0);
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'hFEDC, 16'h0C91, 16'h1234, 16'hFEDC, 16'h0C91};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[3] = '{16'h8001, 16'h0001, 16'h8000, 16'h8001, 16'h0001, 16'h8000};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 16'hC3C3, 16'hA5A5, 16'h5A5A, 16'hC3C3};
        vecs[5] = '{16'h7FFF, 16'h8000, 16'h00FF, 16'h7FFF, 16'h8000, 16'h00FF};

        arst_n = 1'b0; in_valid = 1'b0; xs = 1'b0; ys = 1'b0; zs = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {47'd0, out_valid}, 48'd0);
        chk("reset data", {out_x, out_y, out_z}, 48'd0);
        chk("reset overflow", {47'd0, overflow}, 48'd0);
        chk("reset frame_err", {47'd0, frame_err}, 48'd0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        prime();

        // Single windows with immediate consumption: one-cycle out_valid each.
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].x, vecs[v].y, vecs[v].z, 16, 1'b0);
            in_valid = 1'b0;
            chk($sformatf("vec%0d valid", v), {47'd0, out_valid}, 48'd1);
            chk($sformatf("vec%0d data", v), {out_x, out_y, out_z}, {vecs[v].ex, vecs[v].ey, vecs[v].ez});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d popped", v), {47'd0, out_valid}, 48'd0);
            chk($sformatf("vec%0d ferr", v), {47'd0, frame_err}, 48'd0);
        end

        // Three back-to-back windows into a stalled FIFO: third word lost.
        out_ready = 1'b0;
        send_bits(16'h1111, 16'h2222, 16'h3333, 16, 1'b0);
        send_bits(16'h4444, 16'h5555, 16'h6666, 16, 1'b0);
        send_bits(16'h7777, 16'h8888, 16'h9999, 16, 1'b0);
        in_valid = 1'b0;
        chk("ovf set", {47'd0, overflow}, 48'd1);
        chk("ovf head w1", {out_x, out_y, out_z}, 48'h1111_2222_3333);
        chk("ovf no ferr", {47'd0, frame_err}, 48'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf head w2", {out_x, out_y, out_z}, 48'h4444_5555_6666);
        chk("ovf valid w2", {47'd0, out_valid}, 48'd1);
        @(posedge clk);
        #1;
        chk("ovf drained", {47'd0, out_valid}, 48'd0);
        chk("ovf sticky", {47'd0, overflow}, 48'd1);
        out_ready = 1'b0;

        // Same, but a pop coincides with the third completion: no loss.
        do_reset();
        prime();
        send_bits(16'h1111, 16'h2222, 16'h3333, 16, 1'b0);
        send_bits(16'h4444, 16'h5555, 16'h6666, 16, 1'b0);
        send_bits(16'h7777, 16'h8888, 16'h9999, 16, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("pushpop no ovf", {47'd0, overflow}, 48'd0);
        chk("pushpop head w2", {out_x, out_y, out_z}, 48'h4444_5555_6666);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pushpop head w3", {out_x, out_y, out_z}, 48'h7777_8888_9999);
        chk("pushpop valid w3", {47'd0, out_valid}, 48'd1);
        @(posedge clk);
        #1;
        chk("pushpop drained", {47'd0, out_valid}, 48'd0);

        // Aborted frame after reset (before any completion), then a good window.
        do_reset();
        send_bits(16'hDEAD, 16'hBEEF, 16'hCAFE, 7, 1'b0);
        in_valid = 1'b0;
        chk("abort ferr not yet", {47'd0, frame_err}, 48'd0);
        @(posedge clk);
        #1;
        chk("abort ferr pulse", {47'd0, frame_err}, 48'd1);
        chk("abort no push", {47'd0, out_valid}, 48'd0);
        @(posedge clk);
        #1;
        chk("abort ferr one cycle", {47'd0, frame_err}, 48'd0);
        prime();
        send_bits(16'h0F0F, 16'hF00F, 16'h1357, 16, 1'b0);
        in_valid = 1'b0;
        chk("post-abort valid", {47'd0, out_valid}, 48'd1);
        chk("post-abort data", {out_x, out_y, out_z}, 48'h0F0F_F00F_1357);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-window with the FIFO full and overflow set.
        out_ready = 1'b0;
        send_bits(16'h1111, 16'h2222, 16'h3333, 16, 1'b0);
        send_bits(16'h4444, 16'h5555, 16'h6666, 16, 1'b0);
        send_bits(16'h7777, 16'h8888, 16'h9999, 16, 1'b0);
        chk("pre-rst ovf", {47'd0, overflow}, 48'd1);
        send_bits(16'hAAAA, 16'hBBBB, 16'hCCCC, 5, 1'b0);
        arst_n = 1'b0;
        #2;
        chk("async rst valid", {47'd0, out_valid}, 48'd0);
        chk("async rst ovf", {47'd0, overflow}, 48'd0);
        chk("async rst data", {out_x, out_y, out_z}, 48'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst no ferr", {47'd0, frame_err}, 48'd0);
        arst_n = 1'b1;
        prime();
        out_ready = 1'b1;
        send_bits(16'h2468, 16'h1357, 16'hFACE, 16, 1'b0);
        in_valid = 1'b0;
        chk("post-rst valid", {47'd0, out_valid}, 48'd1);
        chk("post-rst data", {out_x, out_y, out_z}, 48'h2468_1357_FACE);
        @(posedge clk);
        #1;
        chk("post-rst popped", {47'd0, out_valid}, 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
